// File: rtl/demux_1to2_stream_pkg.sv
// Shared definitions for the 1-to-2 stream demux: FSM encodings and route select constants.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package demux_1to2_stream_pkg;

  // Packet routing state. 2'd3 is never entered and behaves like ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROUTE_A = 2'd1,
    ST_ROUTE_B = 2'd2
  } state_t;

  // Destination select values carried on in_sel.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Route for the beat currently on the input: locked mid-packet, taken from sel otherwise.
  function automatic logic route_of(input state_t st, input logic sel);
    logic r;
    case (st)
      ST_ROUTE_A: r = SEL_A;
      ST_ROUTE_B: r = SEL_B;
      default:    r = sel;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/demux_1to2_stream_reg_slice_1.sv
// One-entry valid/ready register slice holding a data beat and its last flag.
// Latency: 1 cycle from load to out_valid.
// Backpressure: free = !out_valid || out_ready, so a drain and a load in the same cycle give no bubble.
module reg_slice_1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             free,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  // The slice can take a new beat when empty or when its current beat leaves this cycle.
  assign free = !out_valid || out_ready;

  // Valid flag: set on load, cleared on a drain without a replacement beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload and last flag only change on load, so they stay stable under backpressure
  // and keep the last delivered beat after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_last <= 1'b0;
    end else if (load) begin
      out_data <= load_data;
      out_last <= load_last;
    end
  end

endmodule

// File: rtl/demux_1to2_stream.sv
// Steers each input packet to port A or B (route picked on the first beat, held to the last); optional beat counters under DEMUX_CNT_EN.
// Latency: 1 cycle from input acceptance to x_valid; 1 beat/cycle per route.
// Backpressure: in_ready follows only the currently routed slice; the other port drains independently.
module demux_1to2_stream
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef DEMUX_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_last,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_last
`ifdef DEMUX_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
`endif
);

  state_t state_q;
  state_t state_d;
  logic   route;
  logic   accept;
  logic   a_free;
  logic   b_free;
  logic   a_load;
  logic   b_load;

  // Route select and input handshake; in IDLE this is combinational on in_sel.
  assign route    = route_of(state_q, in_sel);
  assign in_ready = !rst && ((route == SEL_B) ? b_free : a_free);
  assign accept   = in_valid && in_ready;
  assign a_load   = accept && (route == SEL_A);
  assign b_load   = accept && (route == SEL_B);

  // Packet state register; reset abandons any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: lock the route on a non-final first beat, release it on the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ROUTE_A, ST_ROUTE_B: begin
        if (accept && in_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept && !in_last) begin
          state_d = (in_sel == SEL_B) ? ST_ROUTE_B : ST_ROUTE_A;
        end
      end
    endcase
  end

  reg_slice_1 #(.WIDTH(WIDTH)) u_slice_a (
    .clk       (clk),
    .rst       (rst),
    .load      (a_load),
    .load_data (in_data),
    .load_last (in_last),
    .free      (a_free),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .out_data  (a_data),
    .out_last  (a_last)
  );

  reg_slice_1 #(.WIDTH(WIDTH)) u_slice_b (
    .clk       (clk),
    .rst       (rst),
    .load      (b_load),
    .load_data (in_data),
    .load_last (in_last),
    .free      (b_free),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .out_data  (b_data),
    .out_last  (b_last)
  );

`ifdef DEMUX_CNT_EN
  // Per-port delivered-beat counters; clear wins over a same-cycle increment, wrap is natural.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_valid && a_ready) begin
        a_cnt <= a_cnt + 1'b1;
      end
      if (b_valid && b_ready) begin
        b_cnt <= b_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Self-checking bench for demux_1to2_stream: directed scenarios followed by random traffic against a queue-based model.
// Latency: model expects each accepted beat to be presented on its port the cycle after acceptance.
// Backpressure: random a_ready/b_ready; in_ready predicted from model occupancy of the routed port.
module tb_demux_1to2_stream;

  localparam int WIDTH = 8;
`ifdef DEMUX_CNT_EN
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_last;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
`ifdef DEMUX_CNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] a_cnt;
  logic [CNT_W-1:0] b_cnt;
`endif

  always #5 clk = ~clk;

  demux_1to2_stream #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .a_last   (a_last),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .b_last   (b_last)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  // Model: beats accepted but not yet delivered, per port, plus packet lock and holds.
  beat_t       qa[$];
  beat_t       qb[$];
  bit          m_in_pkt;
  bit          m_route;
  logic [7:0]  a_hd, b_hd;
  logic        a_hl, b_hl;
  logic [15:0] m_acnt, m_bcnt;
  bit          chk_en;
  int          n_chk;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_in_pkt = 0;
    m_route  = 0;
    a_hd = 8'h00; b_hd = 8'h00;
    a_hl = 1'b0;  b_hl = 1'b0;
    m_acnt = '0;  m_bcnt = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic s,
                       input logic l, input logic ar, input logic br, input logic clr);
    logic  rt;
    logic  exp_rdy;
    logic  acc;
    beat_t bt;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; in_sel = s; in_last = l;
    a_ready = ar; b_ready = br;
`ifdef DEMUX_CNT_EN
    cnt_clr = clr;
`endif
    #1;
    rt      = m_in_pkt ? m_route : s;
    exp_rdy = !r && (rt ? (qb.size() == 0 || br) : (qa.size() == 0 || ar));
    if (chk_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      check("a_valid",  {31'd0, a_valid},  {31'd0, qa.size() > 0});
      check("a_data",   {24'd0, a_data},   {24'd0, a_hd});
      check("a_last",   {31'd0, a_last},   {31'd0, a_hl});
      check("b_valid",  {31'd0, b_valid},  {31'd0, qb.size() > 0});
      check("b_data",   {24'd0, b_data},   {24'd0, b_hd});
      check("b_last",   {31'd0, b_last},   {31'd0, b_hl});
`ifdef DEMUX_CNT_EN
      check("a_cnt",    {16'd0, a_cnt},    {16'd0, m_acnt});
      check("b_cnt",    {16'd0, b_cnt},    {16'd0, m_bcnt});
`endif
    end
    acc = v && exp_rdy;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (qa.size() > 0 && ar) begin
        void'(qa.pop_front());
        m_acnt++;
      end
      if (qb.size() > 0 && br) begin
        void'(qb.pop_front());
        m_bcnt++;
      end
      if (clr) begin
        m_acnt = '0;
        m_bcnt = '0;
      end
      if (acc) begin
        bt.d = d;
        bt.l = l;
        if (rt) begin
          qb.push_back(bt); b_hd = d; b_hl = l;
        end else begin
          qa.push_back(bt); a_hd = d; a_hl = l;
        end
        m_in_pkt = !l;
        m_route  = rt;
      end
    end
    chk_en = 1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; chk_en = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; in_last = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
`ifdef DEMUX_CNT_EN
    cnt_clr = 1'b0;
`endif
    model_reset();

    // Reset then idle: ready for either destination afterwards.
    cycle(1, 0, 8'h00, 0, 0, 0, 0, 0);
    cycle(1, 0, 8'h00, 1, 0, 0, 0, 0);
    cycle(0, 0, 8'h00, 0, 0, 0, 0, 0);
    cycle(0, 0, 8'h00, 1, 0, 0, 0, 0);

    // Single-beat steer to B.
    cycle(0, 1, 8'hA5, 1, 1, 1, 1, 0);
    cycle(0, 0, 8'h00, 0, 0, 1, 1, 0);
    cycle(0, 0, 8'h00, 0, 0, 1, 1, 0);

    // Packet lock: in_sel changes mid-packet are ignored.
    cycle(0, 1, 8'h11, 0, 0, 1, 1, 0);
    cycle(0, 1, 8'h22, 1, 0, 1, 1, 0);
    cycle(0, 1, 8'h33, 1, 1, 1, 1, 0);
    cycle(0, 0, 8'h00, 1, 0, 1, 1, 0);

    // Backpressure on A while a new packet flows to B.
    cycle(0, 1, 8'h44, 0, 1, 1, 1, 0);
    cycle(0, 1, 8'h55, 0, 1, 0, 1, 0);
    cycle(0, 1, 8'h66, 1, 1, 0, 1, 0);
    cycle(0, 0, 8'h00, 0, 0, 0, 1, 0);
    cycle(0, 0, 8'h00, 0, 0, 1, 1, 0);
    cycle(0, 0, 8'h00, 0, 0, 1, 1, 0);

    // Streaming: ten back-to-back A beats.
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'(i), 0, (i == 9), 1, 1, 0);
    cycle(0, 0, 8'h00, 0, 0, 1, 1, 0);
    cycle(0, 0, 8'h00, 0, 0, 1, 1, 0);

    // Reset mid-packet on B, then a new packet to A with counter clear on a handshake.
    cycle(0, 1, 8'hB0, 1, 0, 1, 1, 0);
    cycle(0, 1, 8'hB1, 0, 0, 1, 1, 0);
    cycle(1, 0, 8'h00, 0, 0, 1, 1, 0);
    cycle(0, 1, 8'hC0, 0, 0, 1, 1, 0);
    cycle(0, 1, 8'hC1, 1, 1, 1, 1, 0);
    cycle(0, 0, 8'h00, 0, 0, 1, 1, 1);
    cycle(0, 0, 8'h00, 0, 0, 1, 1, 0);

    // Random traffic with occasional resets and clears.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    end
    cycle(0, 0, 8'h00, 0, 0, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_1to2_stream.md
Name: demux_1to2_stream

Overview:
- Counterpart to the datapath 2-to-1 mux: takes one operand/result stream and steers each packet to one of two destinations (port A or port B).
- Handshake on both sides is valid/ready.
- Each output has a one-entry register slice.
- Routing is decided on the first beat of a packet and held until its last beat.
- Sits between the ALU result path and two consumers, for example the writeback and flag/status paths.

Parameters:
- WIDTH, 8, data beat width in bits.
- CNT_W, 16, width of the optional per-port beat counters.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  input beat payload.
- in_sel  in  1  destination, 0=A, 1=B; sampled on the first beat of a packet only.
- in_last  in  1  marks the final beat of a packet.
- a_valid  out  1  port A beat valid.
- a_ready  in  1  port A consumer ready.
- a_data  out  WIDTH  port A payload.
- a_last  out  1  port A last flag.
- b_valid  out  1  port B beat valid.
- b_ready  in  1  port B consumer ready.
- b_data  out  WIDTH  port B payload.
- b_last  out  1  port B last flag.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - a_valid=b_valid=0; a_data=b_data=0; a_last=b_last=0.
  - Any beats held in the slices are discarded and any partial packet is abandoned.
  - in_ready is 0 while rst is high.
- FSM states are IDLE, ROUTE_A and ROUTE_B.
  - IDLE: the route for the current beat is in_sel.
    - Beat accepted with in_last=1: stay IDLE (single-beat packet).
    - Beat accepted with in_last=0: go to ROUTE_A if in_sel=0, else ROUTE_B.
  - ROUTE_A / ROUTE_B: in_sel is ignored and the route is fixed.
    - Accepted beat with in_last=1: return to IDLE.
  - No accepted beat: state holds.
- Slice "free" (per port) = !x_valid || x_ready.
- in_ready = !rst && (free slice of the current route).
  - In IDLE, in_ready depends combinationally on in_sel.
  - Nothing on the input path is combinationally dependent on the other port.
- Accepting a beat:
  - Loads the routed slice: x_valid<=1, x_data<=in_data, x_last<=in_last.
  - Latency is exactly 1 cycle from acceptance to x_valid.
- Output drain: x_valid && x_ready with no new load into that slice gives x_valid<=0. Data and last flags hold their values.
- Simultaneous drain and load on the same slice: the new beat is loaded, x_valid stays 1, and there is no bubble. Full throughput is 1 beat/cycle per route.
- The unselected slice is independent: it keeps draining while the other route is busy.
- Backpressure:
  - With x_valid=1 && x_ready=0, x_data and x_last are stable.
  - in_ready=0 for that route.
- An input beat with in_valid=0 has no effect, and in_data/in_sel/in_last are don't-care.
- No ordering guarantee exists between ports A and B; order within a port is preserved.

Optional Feature:
- DEMUX_CNT_EN defined:
  - Adds outputs a_cnt and b_cnt (CNT_W bits each), both reset to 0.
  - Each counter increments on an output handshake (x_valid && x_ready) and wraps modulo 2^CNT_W.
  - Adds input cnt_clr (1 bit), a synchronous clear. It has priority over an increment in the same cycle.
- DEMUX_CNT_EN undefined: the counters and cnt_clr are absent and there is zero logic.

Decomposition:
- Shared package or include file holds:
  - state encodings ST_IDLE=2'd0, ST_ROUTE_A=2'd1, ST_ROUTE_B=2'd2 (2'd3 is unreachable and is treated as IDLE);
  - the constants SEL_A=1'b0 and SEL_B=1'b1.
- One natural sub-module is reg_slice_1: the one-entry valid/ready slice, instantiated twice (A and B).

Test Plan:
1. Reset then idle:
   - Stimulus: rst high 2 cycles, then low with in_valid=0.
   - Required: a_valid=b_valid=0, data=0, in_ready=0 during rst. After reset, in_ready=1 for either in_sel.
2. Single-beat steer:
   - Stimulus: in_sel=1, in_data=8'hA5, in_last=1, b_ready=1.
   - Required: b_valid=1, b_data=A5, b_last=1 the next cycle; a_valid stays 0; state IDLE.
3. Packet lock:
   - Stimulus: 3-beat packet 11,22,33 with in_sel=0 on beat 1, then in_sel=1 on beats 2 and 3.
   - Required: all 3 beats appear on A in order, last only on 33; B sees nothing.
4. Backpressure:
   - Stimulus: a_ready=0 after the first A beat.
   - Required: a_data holds and in_ready=0 for route A.
   - Stimulus: then a new IDLE packet with in_sel=1.
   - Required: in_ready=1 and it is delivered on B while A stalls.
5. Streaming:
   - Stimulus: a_ready=1 and 10 back-to-back A beats 0..9.
   - Required: one beat/cycle with no bubbles; a_valid is continuous.
6. Reset mid-packet:
   - Stimulus: rst pulse after beat 2 of 4 on B, then a new packet with in_sel=0.
   - Required: b_valid=0 after reset; the new packet goes to A (state was IDLE).
   - With DEMUX_CNT_EN: b_cnt=0 after reset, a_cnt increments per A handshake, and cnt_clr in the same cycle as a handshake leaves 0.
